risc_fetch: RTL
===============

// Module: risc_fetch
// PURPOSE
//  Instruction-fetch initiator for the RISC32 core: the requesting end of the instruction-ROM address/data port.
//  Holds the PC, drives imem_addr, samples imem_data after a fixed number of wait states and presents the word
//  to decode on a valid/ready handshake. Accepts PC redirects from execute; optionally folds GOTO in-stage.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded on reset (low 2 bits must be 0)
//  WAIT_STATES  0              extra cycles imem_data needs after imem_addr is stable (0..15)
//  CNT_W        4              wait-state counter width; WAIT_STATES < 2**CNT_W
// PORTS
//  clk             in   1   single clock, all state updates on posedge
//  reset           in   1   synchronous, active-high
//  imem_addr       out  32  byte address to instruction ROM (= pc_q, registered)
//  imem_data       in   32  instruction word from ROM
//  instr           out  32  captured instruction
//  instr_pc        out  32  address instr was fetched from
//  instr_valid     out  1   instr/instr_pc valid
//  instr_ready     in   1   decode accepts; transfer when valid & ready
//  redirect_valid  in   1   execute requests PC change (one-cycle pulse)
//  redirect_pc     in   32  new PC; bits [1:0] ignored (forced 0)
// BEHAVIOUR
//  Reset (sync, active-high): pc_q=RESET_PC, state=S_FETCH, wait_cnt=0, instr=0, instr_pc=0, instr_valid=0.
//  States: S_FETCH (address out, counting), S_VALID (word held for decode).
//  S_FETCH entered at cycle t: imem_addr=pc_q; wait_cnt increments each cycle; when wait_cnt==WAIT_STATES
//   (cycle t+WAIT_STATES) instr<=imem_data, instr_pc<=pc_q, wait_cnt<=0 -> S_VALID; instr_valid=1 at t+WAIT_STATES+1.
//  S_VALID: instr, instr_pc, imem_addr held stable while instr_ready=0. On valid&ready: pc_q<=next_pc,
//   instr_valid<=0 -> S_FETCH. Throughput: one instruction per WAIT_STATES+2 cycles with ready=1.
//  next_pc = pc_q+4, 32-bit modulo (0xFFFF_FFFC -> 0x0000_0000); no overflow flag.
//  Redirect: redirect_valid highest priority in any state: pc_q<={redirect_pc[31:2],2'b00}, wait_cnt<=0,
//   instr_valid<=0, -> S_FETCH. Same cycle as valid&ready: transfer completes (decode keeps that word),
//   redirect PC wins over next_pc. Redirect during S_FETCH abandons the in-flight fetch.
//  Reset beats redirect and handshake; reset mid-wait discards the fetch, outputs return to reset values.
//  instr_valid never drops without a transfer, a redirect or reset.
// CONFIGURATION
//  RISC32_FETCH_GOTO_EN defined: on capture, if imem_data[31:26]==OP_GOTO, instruction is consumed in-stage:
//   not presented (instr_valid stays 0), pc_q<=pc_q+4+(sext(imem_data[25:0])<<2), back to S_FETCH next cycle;
//   a redirect in that cycle still wins.
//  Undefined: GOTO presented to decode like any other word; PC changes only through redirect.
// STRUCTURE
//  Opcode constants (OP_GOTO etc.) and register names come from the shared opcodes include; the fetch state
//   encodings (S_FETCH, S_VALID) and a JUMP_SHIFT=2 constant are added there for the decode/execute users.
//  Single module; jump-target adder is a small function inside it. No sub-module needed.
// TESTING
//  T1: reset, WAIT_STATES=0, ready=1, six-word ROM (LDI,LDI,LDI,ADD,SUB,GOTO -6 at 0x14) -> instr_pc sequence
//      0x0,0x4,0x8,0xC,0x10 (GOTO_EN) then 0x0; without GOTO_EN 0x14 presented, then 0x18.
//  T2: ready=0 for 5 cycles with instr_valid=1 at pc 0x8 -> instr, instr_pc=0x8, imem_addr=0x8 constant; ready=1 -> next fetch 0xC.
//  T3: redirect_valid with redirect_pc=0x0000_0102 during S_FETCH -> imem_addr=0x100 next cycle, old fetch never valid.
//  T4: redirect to 0x40 in same cycle as valid&ready at pc 0x4 -> word at 0x4 accepted once, next instr_pc=0x40.
//  T5: WAIT_STATES=3, ROM output delayed 3 cycles -> instr_valid rises 4 cycles after S_FETCH entry, correct word.
//  T6: redirect to 0xFFFF_FFFC, transfer -> next imem_addr=0x0; reset asserted mid-wait -> instr_valid=0, pc=RESET_PC.

Source files
------------

// File: rtl/risc_fetch_pkg.sv
// Shared RISC32 constants: opcodes, register names, fetch state encodings
// and the jump-offset shift used by fetch, decode and execute.
package risc_fetch_pkg;

  // Primary opcodes live in instruction bits [31:26].
  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_LDI  = 6'h01;
  localparam logic [5:0] OP_GOTO = 6'h02;
  localparam logic [5:0] OP_ADD  = 6'h03;
  localparam logic [5:0] OP_SUB  = 6'h04;

  // Register names used by the assembler-style encodings.
  localparam logic [4:0] R0 = 5'd0;
  localparam logic [4:0] R1 = 5'd1;
  localparam logic [4:0] R2 = 5'd2;
  localparam logic [4:0] R3 = 5'd3;

  // Word offsets are turned into byte offsets by this shift.
  localparam int JUMP_SHIFT = 2;

  // Fetch stage states: address out and counting, or word held for decode.
  typedef enum logic {
    S_FETCH = 1'b0,
    S_VALID = 1'b1
  } fetch_state_e;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/risc_fetch.sv
// RISC32 instruction-fetch initiator. Drives the ROM address from the PC,
// captures the ROM word after WAIT_STATES extra cycles and holds it on a
// valid/ready handshake towards decode. Execute may redirect the PC at any
// time. Optional in-stage GOTO folding: define RISC32_FETCH_GOTO_EN.
module risc_fetch
  import risc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          WAIT_STATES = 0,
  parameter int          CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  // Counter value on which the ROM word is guaranteed stable.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_STATES);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      instr_pc_q, instr_pc_d;
  logic             is_goto;
  logic [31:0]      goto_target;

`ifdef RISC32_FETCH_GOTO_EN
  // Target of a GOTO: the following word plus the signed word offset.
  function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                              input logic [25:0] offs);
    logic [31:0] sext;
    sext = {{6{offs[25]}}, offs};
    return pc + 32'd4 + (sext << JUMP_SHIFT);
  endfunction

  assign is_goto     = (imem_data[31:26] == OP_GOTO);
  assign goto_target = jump_target(pc_q, imem_data[25:0]);
`else
  // Without folding every word goes to decode and the PC only moves by
  // sequential advance or redirect.
  assign is_goto     = 1'b0;
  assign goto_target = pc_q;
`endif

  // Next-state logic: fetch/hold sequencing, then redirect overrides all.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wait_cnt_d = wait_cnt_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    case (state_q)
      S_FETCH: begin
        if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = '0;
          if (is_goto) begin
            // Jump consumed here; start fetching the target next cycle.
            pc_d = goto_target;
          end else begin
            instr_d    = imem_data;
            instr_pc_d = pc_q;
            state_d    = S_VALID;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_VALID: begin
        if (instr_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // A redirect abandons any in-flight fetch; a word transferred in the
    // same cycle still belongs to decode, but the redirect PC wins.
    if (redirect_valid) begin
      pc_d       = align_pc(redirect_pc);
      wait_cnt_d = '0;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      state_d    = S_FETCH;
    end
  end

  // State registers with synchronous reset, which beats every other request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      wait_cnt_q <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wait_cnt_q <= wait_cnt_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = (state_q == S_VALID);

endmodule
